// File: rtl/fas_pkg.sv
// Shared constants, bin field helpers and scheduler state encoding for the
// FAS post-FFT peak search.
package fas_pkg;

  localparam int NUM_BINS = 16;
  localparam int BIN_W    = 32;
  localparam int MAG_W    = 32;
  localparam int IDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  function automatic logic signed [15:0] bin_re(input logic [BIN_W-1:0] bin);
    return bin[31:16];
  endfunction

  function automatic logic signed [15:0] bin_im(input logic [BIN_W-1:0] bin);
    return bin[15:0];
  endfunction

endpackage

// File: rtl/fas_peak_ctrl_if.sv
// FFT-frame input and peak-report output bundle between the FFT datapath
// (master) and the peak scheduler (slave).
interface fas_peak_ctrl_if #(
  parameter int FRAME_CNT_W = 8
);
  import fas_pkg::*;

  logic                               fft_valid;
  logic [NUM_BINS-1:0][BIN_W-1:0]     fft_d;
  logic                               busy;
  logic                               done;
  logic [IDX_W-1:0]                   freq;
  logic [MAG_W-1:0]                   peak_mag;
  logic [FRAME_CNT_W-1:0]             frame_cnt;
  logic                               overrun;

  modport master (
    output fft_valid, fft_d,
    input  busy, done, freq, peak_mag, frame_cnt, overrun
  );

  modport slave (
    input  fft_valid, fft_d,
    output busy, done, freq, peak_mag, frame_cnt, overrun
  );

endinterface

// File: rtl/fas_bin_mag.sv
// Combinational squared magnitude of one FFT bin: re^2 + im^2 as a 32-bit
// unsigned value (largest result 2^31, so no wrap).
module fas_bin_mag
  import fas_pkg::*;
(
  input  logic [BIN_W-1:0] bin,
  output logic [MAG_W-1:0] mag
);

  logic signed [31:0] re_x;
  logic signed [31:0] im_x;
  logic signed [31:0] re_sq;
  logic signed [31:0] im_sq;

  assign re_x  = 32'(bin_re(bin));
  assign im_x  = 32'(bin_im(bin));
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  // Each square is at most 2^30; summing as unsigned keeps the 2^31 corner exact.
  assign mag   = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fas_peak_ctrl.sv
// Post-FFT scheduler: scans the 16 captured bins one per cycle, reports the
// strongest bin, and arbitrates back-to-back frames with a one-deep pending slot.
module fas_peak_ctrl
  import fas_pkg::*;
#(
  parameter int          NUM_BINS    = 16,
  parameter int unsigned SKIP_DC     = 0,
  parameter int          FRAME_CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  fas_peak_ctrl_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BINS - 1);
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(SKIP_DC != 0);

  state_t                         state;
  state_t                         state_nxt;
  logic [fas_pkg::NUM_BINS-1:0][BIN_W-1:0] frame_buf;
  logic [IDX_W-1:0]               idx;
  logic [IDX_W-1:0]               best_idx;
  logic [MAG_W-1:0]               best_mag;
  logic [MAG_W-1:0]               mag;
  logic [IDX_W-1:0]               best_idx_nxt;
  logic [MAG_W-1:0]               best_mag_nxt;
  logic                           take;
  logic                           capture;
  logic                           scan_last;
  logic                           pending;
  logic                           busy;
  logic                           done;
  logic [IDX_W-1:0]               freq;
  logic [MAG_W-1:0]               peak_mag;
  logic [FRAME_CNT_W-1:0]         frame_cnt;
  logic                           overrun;

  fas_bin_mag u_bin_mag (
    .bin (frame_buf[idx]),
    .mag (mag)
  );

  // NOTE: every always_ff here uses non-blocking assignments so all state
  // updates on an edge see the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: defaults first so no path through the case leaves an output
  // unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.fft_valid) state_nxt = SCAN;
      SCAN:    if (idx == LAST_IDX) state_nxt = REPORT;
      REPORT:  state_nxt = (pending || bus.fft_valid) ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SCAN:    busy = 1'b1;
      REPORT:  begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // The first candidate is taken unconditionally, so an all-zero frame still
  // reports the lowest eligible bin; later bins must be strictly larger.
  assign take         = (idx == FIRST_IDX) || ((idx > FIRST_IDX) && (mag > best_mag));
  assign best_idx_nxt = take ? idx : best_idx;
  assign best_mag_nxt = take ? mag : best_mag;
  assign capture      = ((state == IDLE) && bus.fft_valid) ||
                        ((state == REPORT) && (pending || bus.fft_valid));
  assign scan_last    = (state == SCAN) && (idx == LAST_IDX);

  // NOTE: the frame buffer carries no reset; it is always rewritten at capture
  // before any bin is read, so resetting it would only cost logic.
  always_ff @(posedge clk) begin
    if (capture) frame_buf <= bus.fft_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      best_idx  <= '0;
      best_mag  <= '0;
      freq      <= '0;
      peak_mag  <= '0;
      frame_cnt <= '0;
      pending   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (capture) begin
        idx      <= '0;
        best_idx <= '0;
        best_mag <= '0;
      end else if (state == SCAN) begin
        idx      <= idx + 1'b1;
        best_idx <= best_idx_nxt;
        best_mag <= best_mag_nxt;
      end

      // Results land on the edge into REPORT so they are valid alongside done.
      if (scan_last) begin
        freq      <= best_idx_nxt;
        peak_mag  <= best_mag_nxt;
        frame_cnt <= frame_cnt + 1'b1;
      end

      if (state == SCAN && bus.fft_valid) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end else if (state == REPORT) begin
        pending <= 1'b0;
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.freq      = freq;
  assign bus.peak_mag  = peak_mag;
  assign bus.frame_cnt = frame_cnt;
  assign bus.overrun   = overrun;

endmodule
